// File: rtl/lsu_dmem_master.sv
// Load/store initiator between the memory stage and a single-port, combinationally read data memory.
// One request in flight; sub-word stores are merged by read-modify-write.
module lsu_dmem_master #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_reg;
    logic        store_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  lane_reg;
    logic [15:0] wdata_reg;
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;
    logic [31:0] mem_a_reg;
    logic [31:0] mem_wd_reg;

    logic        funct3_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic [3:0]  lane_hit;

    always_comb begin
        funct3_bad   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                    || (req_funct3[2] && req_store);
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                    || ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
        out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
        req_err      = funct3_bad || misaligned || out_of_range;
    end

    always_comb begin
        byte_sel  = mem_RD[{lane_reg, 3'b000} +: 8];
        half_sel  = mem_RD[{lane_reg[1], 4'b0000} +: 16];
        load_data = mem_RD;
        case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_RD;
        endcase
    end

    // Per-lane merge: SB replicates wdata[7:0], SH maps wdata[15:0] onto the addressed half.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_hit[gi] = funct3_reg[0] ? (lane_reg[1] == 1'(gi / 2))
                                            : (lane_reg == 2'(gi));
        assign merged_word[8*gi +: 8] = !lane_hit[gi] ? mem_RD[8*gi +: 8]
                                      : (funct3_reg[0] ? wdata_reg[8*(gi % 2) +: 8]
                                                       : wdata_reg[7:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            store_reg      <= 1'b0;
            funct3_reg     <= 3'd0;
            lane_reg       <= 2'd0;
            wdata_reg      <= 16'd0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'd0;
            mem_a_reg      <= 32'd0;
            mem_wd_reg     <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= 32'd0;
                    mem_wd_reg     <= 32'd0;
                    if (req_valid) begin
                        store_reg     <= req_store;
                        funct3_reg    <= req_funct3;
                        lane_reg      <= req_addr[1:0];
                        wdata_reg     <= req_wdata[15:0];
                        req_ready_reg <= 1'b0;
                        if (req_err) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                        end else begin
                            mem_a_reg <= {req_addr[31:2], 2'b00};
                            if (req_store && (req_funct3 == 3'b010)) begin
                                state_reg  <= WRITE;
                                mem_wd_reg <= req_wdata;
                            end else begin
                                state_reg <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (store_reg) begin
                        state_reg  <= WRITE;
                        mem_wd_reg <= merged_word;
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_data;
                    end
                end
                WRITE: begin
                    state_reg      <= RESP;
                    mem_wd_reg     <= 32'd0;
                    resp_valid_reg <= 1'b1;
                end
                RESP: begin
                    state_reg      <= IDLE;
                    req_ready_reg  <= 1'b1;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= 32'd0;
                end
            endcase
        end
    end

    // Gated by reset so an aborted store can never commit on the reset edge.
    assign mem_WE     = (state_reg == WRITE) && !reset;
    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign mem_A      = mem_a_reg;
    assign mem_WD     = mem_wd_reg;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboard bench for lsu_dmem_master: a reference memory model predicts each response and write.
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        wr;
        int          idx;
        logic [31:0] wword;
        int          acc;
        int          wes;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nresp = 0;
    int          nacc = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    lsu_dmem_master #(.MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_A(mem_a), .mem_WD(mem_wd), .mem_WE(mem_we), .mem_RD(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t predict(input logic st, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        logic legal, aligned;
        int nbytes, lane;
        logic [31:0] w, v;
        e = '{rdata: 32'd0, err: 1'b0, lat: 1, wr: 1'b0, idx: 0, wword: 32'd0, acc: 0, wes: 0};
        legal   = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes  = 1 << f3[1:0];
        aligned = (a % nbytes) == 0;
        if (!legal || !aligned || a >= 32'd256) begin
            e.err = 1'b1;
            return e;
        end
        e.idx = int'(a[7:2]);
        lane  = int'(a[1:0]);
        w     = ref_mem[e.idx];
        if (!st) begin
            e.lat = 2;
            v = 32'd0;
            for (int k = 0; k < nbytes; k++) v[8*k +: 8] = w[8*(lane+k) +: 8];
            if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
            e.rdata = v;
        end else begin
            e.wr  = 1'b1;
            e.lat = (nbytes == 4) ? 2 : 3;
            v = w;
            for (int k = 0; k < nbytes; k++) v[8*(lane+k) +: 8] = wd[8*k +: 8];
            e.wword = v;
        end
        return e;
    endfunction

    // Monitor: samples on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (mem_we) begin
                check("we_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    q[0].wes++;
                    check("we_addr", mem_a, {22'd0, 8'(q[0].idx), 2'b00});
                    check("we_data", mem_wd, q[0].wword);
                    check("we_cycle", 32'(cyc - q[0].acc), 32'(q[0].lat - 1));
                end
            end
            if (resp_valid) begin
                check("resp_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
                    check("we_count", 32'(e.wes), {31'd0, e.wr});
                    if (e.wr) ref_mem[e.idx] = e.wword;
                    $display("resp %0d: rdata=%h err=%b latency=%0d", nresp, resp_rdata, resp_err, cyc - e.acc);
                end
                last_rdata = resp_rdata;
                last_err   = resp_err;
                nresp++;
            end
            if (req_valid && req_ready) begin
                exp_t e;
                e = predict(req_store, req_funct3, req_addr, req_wdata);
                e.acc = cyc;
                q.push_back(e);
                nacc++;
            end
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n0;
        bit ok;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(posedge clk); #1;
            ok = req_ready;
        end
        if (!ok) check("ready_timeout", {31'd0, req_ready}, 32'd1);
        n0 = nresp;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int t = 0; t < 10 && nresp == n0; t++) @(negedge clk);
        if (nresp == n0) check("resp_timeout", 32'(nresp), 32'(n0 + 1));
    endtask

    initial begin
        int r0, a0;
        bit dropped;
        logic [2:0] f3_pool [8];
        f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        mem[0] = 32'hFACE_FACE; ref_mem[0] = 32'hFACE_FACE;
        mem[1] = 32'h0000_0002; ref_mem[1] = 32'h0000_0002;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);

        do_req(1'b0, 3'b010, 32'h0, 32'd0); check("lw_0", last_rdata, 32'hFACE_FACE);
        do_req(1'b0, 3'b001, 32'h2, 32'd0); check("lh_2", last_rdata, 32'hFFFF_FACE);
        do_req(1'b0, 3'b101, 32'h2, 32'd0); check("lhu_2", last_rdata, 32'h0000_FACE);
        do_req(1'b0, 3'b000, 32'h1, 32'd0); check("lb_1", last_rdata, 32'hFFFF_FFFA);
        do_req(1'b0, 3'b100, 32'h3, 32'd0); check("lbu_3", last_rdata, 32'h0000_00FA);
        do_req(1'b0, 3'b000, 32'h0, 32'd0); check("lb_0", last_rdata, 32'hFFFF_FFCE);
        do_req(1'b1, 3'b000, 32'h5, 32'h1234_56AB); check("sb_word1", mem[1], 32'h0000_AB02);
        do_req(1'b1, 3'b001, 32'h6, 32'h0000_BEEF); check("sh_word1", mem[1], 32'hBEEF_AB02);
        do_req(1'b1, 3'b010, 32'h3, 32'h1111_1111); check("sw_mis_err", {31'd0, last_err}, 32'd1);
        do_req(1'b0, 3'b001, 32'h1, 32'd0);         check("lh_mis_err", {31'd0, last_err}, 32'd1);
        do_req(1'b0, 3'b010, 32'h100, 32'd0);       check("lw_oor_err", {31'd0, last_err}, 32'd1);
        do_req(1'b1, 3'b011, 32'h0, 32'd0);         check("f3_011_err", {31'd0, last_err}, 32'd1);

        // Back-to-back with req_valid held high throughout.
        @(posedge clk); #1;
        r0 = nresp; a0 = nacc; dropped = 0;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'd0;
        @(posedge clk); #1;
        req_store = 1'b1; req_addr = 32'hFC; req_wdata = 32'h0000_FACE;
        @(negedge clk);
        check("busy_ready", {31'd0, req_ready}, 32'd0);
        for (int t = 0; t < 30 && nresp < r0 + 2; t++) begin
            @(negedge clk);
            if (nacc == a0 + 2 && !dropped) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
                dropped = 1;
            end
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_resp_count", 32'(nresp - r0), 32'd2);
        check("b2b_word63", mem[63], 32'h0000_FACE);

        // Reset lands in the READ cycle of an SH; it must vanish without a trace.
        @(posedge clk); #1;
        r0 = nresp;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0; req_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_we_in_reset", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
            check("abort_no_we", {31'd0, mem_we}, 32'd0);
        end
        check("abort_word0", mem[0], 32'hFACE_FACE);
        check("abort_resp_count", 32'(nresp - r0), 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 32'h10F);
            if ($urandom_range(0, 3) != 0) a = a & ~32'h1;
            do_req(1'($urandom_range(0, 1)), f3_pool[$urandom_range(0, 7)], a, $urandom);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        for (int i = 0; i < 64; i++) check($sformatf("final_word%0d", i), mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store initiator between the core's memory stage and the single-port data memory.
  - Data memory: 64 x 32-bit words, word-addressed by A[31:2], combinational read RD, write on posedge clk when WE.
- Accepts one RV32I load/store request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives the memory, extracts and sign/zero-extends load data, and merges sub-word stores by read-modify-write.
- Returns one response per request; misaligned and out-of-range accesses get an error response and never touch memory.

Parameters:
MEM_WORDS, 64, data-memory depth in words; word index (addr[31:2]) >= MEM_WORDS is an access fault

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for SB/SH)
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal funct3
mem_A  out  32  address to data memory, always word-aligned ({addr[31:2],2'b00})
mem_WD  out  32  write data to data memory
mem_WE  out  1  write enable to data memory
mem_RD  in  32  combinational read data from data memory

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_A=0; mem_WD=0; mem_WE=0.
- reset has priority over all transitions, including mid-operation; no response is issued for an aborted request.
- mem_WE = (state==WRITE) && !reset, so no write commits on a reset cycle.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store, funct3, addr and wdata.
  - Error check, in this order: illegal funct3 (011, 11x, or BU/HU with req_store=1); H/HU with addr[0]!=0; W with addr[1:0]!=0; addr[31:2] >= MEM_WORDS. Any error -> RESP with err=1.
  - SW -> WRITE.
  - Any load, SB or SH -> READ.
- req_ready=0 in every state except IDLE; requests presented while busy are ignored, not queued.
- READ:
  - mem_A driven; capture mem_RD at the clock edge.
  - Load -> RESP with resp_rdata set as follows:
    - Byte lane = addr[1:0] (bits 8*lane+7 : 8*lane); half lane = addr[1] (bits 16*h+15 : 16*h).
    - B/H sign-extend; BU/HU zero-extend; W passes the word through.
  - SB/SH -> WRITE with merged word = captured word with the addressed lane replaced by wdata[7:0] or wdata[15:0].
- WRITE:
  - mem_WE=1 for exactly this one cycle.
  - mem_WD = merged word (SB/SH) or wdata (SW).
  - -> RESP.
- RESP:
  - resp_valid=1 for one cycle; resp_rdata and resp_err are valid only this cycle, 0 otherwise.
  - -> IDLE. A new request is accepted on the following cycle.
- Latency, with the acceptance edge as cycle 0, resp_valid is high in:
  - cycle 1 for an error;
  - cycle 2 for loads and SW;
  - cycle 3 for SB/SH.
- mem_A holds the latched aligned address from READ through RESP; mem_WD is 0 outside WRITE.

Test Plan:
- Memory word0=0xFACEFACE, word1=0x00000002. LW 0x0 -> resp_valid in cycle 2, rdata=0xFACEFACE, err=0, mem_WE never high.
- LH 0x2 -> 0xFFFFFACE; LHU 0x2 -> 0x0000FACE; LB 0x1 -> 0xFFFFFFFA; LBU 0x3 -> 0x000000FA; LB 0x0 -> 0xFFFFFFCE.
- SB 0x5, wdata=0x123456AB -> single mem_WE pulse in cycle 2 with mem_A=0x4, mem_WD=0x0000AB02; resp cycle 3. SH 0x6, wdata=0xBEEF -> word1=0xBEEFAB02.
- SW 0x3; LH 0x1; LW 0x100 (index 64) -> resp_err=1 in cycle 1, rdata=0, no mem_WE. SB with funct3=011 -> err=1.
- req_valid held high across back-to-back LW 0x0 then SW 0xFC (wdata=0xFACE) -> req_ready low while busy; exactly two responses in order; word63=0x0000FACE.
- Reset asserted in the READ cycle of SH 0x0 -> next cycle IDLE, req_ready=1, no mem_WE, no resp_valid; memory word0 unchanged.
